mips_trace_unit: RTL and testbench

Hardware trace port for the single-cycle MIPS core. Each clock in which tracing is enabled, it captures the retiring instruction's PC, instruction word, write-back value and control flags into a small FIFO. It streams each record out as a 4-word frame over a valid/ready interface to an off-core logger. It is the producing end of the observation path: it drives what the bench/logger consumes, instead of the bench probing top-level datapath wires.

---
 rtl/mips_trace_pkg.sv | 26 ++
 rtl/mips_trace_if.sv | 18 +
 rtl/trace_fifo.sv | 47 ++++
 rtl/mips_trace_unit.sv | 117 +++++++++++
 tb/tb_mips_trace_unit.sv | 307 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mips_trace_pkg.sv
// mips_trace_pkg: shared constants, record layout and serializer states for the MIPS trace port.
// Contents:
//   TRACE_HDR    - marker byte at the top of every header word
//   TRACE_REC_W  - width of one captured record as stored in the FIFO
//   REC_*        - LSB offsets of each record field
//   state_t      - serializer FSM states
package mips_trace_pkg;

    localparam logic [7:0] TRACE_HDR = 8'hA5;

    // Record layout, LSB first: dest, MemWrite, RegWrite, drops, seq, wb, instr, pc.
    // The two bits above pc are reserved and always written as zero.
    localparam int TRACE_REC_W = 121;
    localparam int REC_DEST    = 0;
    localparam int REC_MW      = 5;
    localparam int REC_RW      = 6;
    localparam int REC_DROPS   = 7;
    localparam int REC_SEQ     = 15;
    localparam int REC_WB      = 23;
    localparam int REC_INSTR   = 55;
    localparam int REC_PC      = 87;
    localparam int REC_RSVD    = 119;

    typedef enum logic [2:0] {IDLE, HDR, PC, INSTR, WB} state_t;

endpackage

// File: rtl/mips_trace_if.sv
// mips_trace_if: word stream from the trace unit to the off-core logger.
// Signals:
//   out_data  - 32-bit frame word
//   out_valid - out_data is valid
//   out_last  - final word of a 4-word frame
//   out_ready - consumer accepts the word when out_valid && out_ready
// Modports: master (trace unit), slave (logger).
interface mips_trace_if;

    logic [31:0] out_data;
    logic        out_valid;
    logic        out_last;
    logic        out_ready;

    modport master (output out_data, out_valid, out_last, input out_ready);
    modport slave  (input out_data, out_valid, out_last, output out_ready);

endinterface

// File: rtl/trace_fifo.sv
// trace_fifo: synchronous show-ahead FIFO holding captured trace records.
// Ports:
//   clk, rst_n - clock, asynchronous active-low reset (empties the FIFO)
//   push, din  - write din when not full
//   pop        - advance the read pointer when not empty
//   dout       - current head record (valid whenever !empty)
//   full       - DEPTH records held; empty - no records held
module trace_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 121
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;

    // The extra pointer MSB tells a wrapped (full) FIFO from an empty one.
    assign empty = wr_ptr == rd_ptr;
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign dout  = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (pop && !empty) rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push && !full) mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/mips_trace_unit.sv
// mips_trace_unit: captures one retiring-instruction record per enabled cycle and streams it as 4-word frames.
// Ports:
//   clk, rst_n          - core clock, asynchronous active-low reset
//   trace_en            - capture enable, sampled each rising edge
//   q_pc, Instruction   - PC and instruction word of the retiring instruction
//   output_mux_4        - write-back data
//   output_mux_1        - destination register
//   RegWrite, MemWrite  - write strobes
//   trace               - mips_trace_if master: out_data/out_valid/out_last/out_ready
//   fifo_full           - FIFO holds DEPTH records
// Frame: W0 header {A5, seq, drops, RegWrite, MemWrite, 0, dest}, W1 pc, W2 instr, W3 wb (out_last).
module mips_trace_unit
    import mips_trace_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        trace_en,
    input  logic [31:0] q_pc,
    input  logic [31:0] Instruction,
    input  logic [31:0] output_mux_4,
    input  logic [4:0]  output_mux_1,
    input  logic        RegWrite,
    input  logic        MemWrite,
    mips_trace_if.master trace,
    output logic        fifo_full
);

    logic [7:0]             seq_q;
    logic [7:0]             drops_q;
    logic                   push;
    logic                   pop;
    logic                   empty;
    logic                   accept;
    logic [TRACE_REC_W-1:0] rec;
    logic [TRACE_REC_W-1:0] head;
    logic [TRACE_REC_W-1:0] frame_q;
    logic [31:0]            hdr_word;
    logic                   unused_rsvd;
    state_t                 state_q;
    state_t                 state_d;

    // Fullness is the registered occupancy before this edge, so a same-cycle pop never makes room.
    assign push = trace_en && !fifo_full;
    assign rec  = {2'b00, q_pc, Instruction, output_mux_4, seq_q, drops_q, RegWrite, MemWrite, output_mux_1};

    trace_fifo #(.DEPTH(DEPTH), .WIDTH(TRACE_REC_W)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .din   (rec),
        .dout  (head),
        .full  (fifo_full),
        .empty (empty)
    );

    // seq numbers every stored record; drops counts records lost since the last stored one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seq_q   <= '0;
            drops_q <= '0;
        end else if (trace_en) begin
            if (!fifo_full) begin
                seq_q   <= seq_q + 8'd1;
                drops_q <= '0;
            end else if (drops_q != 8'hFF) begin
                drops_q <= drops_q + 8'd1;
            end
        end
    end

    assign accept = trace.out_valid && trace.out_ready;

    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        case (state_q)
            IDLE:  if (!empty) begin
                       state_d = HDR;
                       pop     = 1'b1;
                   end
            HDR:   if (accept) state_d = PC;
            PC:    if (accept) state_d = INSTR;
            INSTR: if (accept) state_d = WB;
            WB:    if (accept) begin
                       state_d = empty ? IDLE : HDR;
                       pop     = !empty;
                   end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            frame_q <= '0;
        end else begin
            state_q <= state_d;
            if (pop) frame_q <= head;
        end
    end

    // Outputs decode only registered state, so they hold stable while stalled.
    assign hdr_word = {TRACE_HDR, frame_q[REC_SEQ +: 8], frame_q[REC_DROPS +: 8],
                       frame_q[REC_RW], frame_q[REC_MW], 1'b0, frame_q[REC_DEST +: 5]};
    assign unused_rsvd = ^frame_q[TRACE_REC_W-1:REC_RSVD];

    assign trace.out_valid = state_q != IDLE;
    assign trace.out_last  = state_q == WB;
    assign trace.out_data  = state_q == HDR   ? hdr_word :
                             state_q == PC    ? frame_q[REC_PC +: 32] :
                             state_q == INSTR ? frame_q[REC_INSTR +: 32] :
                             state_q == WB    ? frame_q[REC_WB +: 32] : '0;

endmodule

// File: tb/tb_mips_trace_unit.sv
// tb_mips_trace_unit: scoreboard bench for mips_trace_unit with a transaction-level reference model.
module tb_mips_trace_unit;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        trace_en = 1'b0;
    logic [31:0] pc = '0;
    logic [31:0] instr = '0;
    logic [31:0] wb = '0;
    logic [4:0]  dest = '0;
    logic        reg_write = 1'b0;
    logic        mem_write = 1'b0;
    logic        fifo_full;

    mips_trace_if bus();

    always #5 clk = ~clk;

    mips_trace_unit #(.DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .trace_en     (trace_en),
        .q_pc         (pc),
        .Instruction  (instr),
        .output_mux_4 (wb),
        .output_mux_1 (dest),
        .RegWrite     (reg_write),
        .MemWrite     (mem_write),
        .trace        (bus),
        .fifo_full    (fifo_full)
    );

    int tests_run = 0;
    int fails = 0;

    // Reference model: records waiting in the FIFO (occ), words left of the frame being sent,
    // sequence/drop counters, and the expected word stream {last, data}.
    logic [32:0] exp_q[$];
    int occ = 0;
    int words_left = 0;
    int m_seq = 0;
    int m_drops = 0;
    int words_seen = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic void model_step();
        bit full;
        full = (occ == DEPTH);
        if (words_left > 0 && bus.out_ready) words_left--;
        if (words_left == 0 && occ > 0) begin
            occ--;
            words_left = 4;
        end
        if (trace_en) begin
            if (!full) begin
                exp_q.push_back({1'b0, 8'hA5, 8'(m_seq), 8'(m_drops), reg_write, mem_write, 1'b0, dest});
                exp_q.push_back({1'b0, pc});
                exp_q.push_back({1'b0, instr});
                exp_q.push_back({1'b1, wb});
                occ++;
                m_seq = (m_seq + 1) % 256;
                m_drops = 0;
            end else if (m_drops < 255) begin
                m_drops++;
            end
        end
    endfunction

    function automatic void model_clear();
        exp_q.delete();
        occ = 0;
        words_left = 0;
        m_seq = 0;
        m_drops = 0;
    endfunction

    task automatic cycle();
        @(posedge clk);
        if (rst_n) model_step();
        @(negedge clk);
    endtask

    task automatic rand_inputs();
        pc        = $urandom;
        instr     = $urandom;
        wb        = $urandom;
        dest      = 5'($urandom_range(0, 31));
        reg_write = 1'($urandom_range(0, 1));
        mem_write = 1'($urandom_range(0, 1));
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_clear();
        repeat (2) cycle();
        rst_n = 1'b1;
    endtask

    task automatic drain();
        int n;
        trace_en = 1'b0;
        bus.out_ready = 1'b1;
        n = 0;
        while ((exp_q.size() != 0 || words_left != 0 || occ != 0) && n < 400) begin
            cycle();
            n++;
        end
        if (n >= 400) begin
            tests_run++;
            fails++;
            $display("FAIL drain_timeout: got %0d words pending, expected 0", exp_q.size());
        end
        repeat (2) cycle();
    endtask

    // Monitor: compares every accepted word against the scoreboard and checks stall stability.
    logic        prev_stall = 1'b0;
    logic [31:0] prev_data = '0;
    logic        prev_last = 1'b0;

    always begin
        logic [32:0] e;
        @(negedge clk);
        #1;
        if (rst_n) begin
            chk("fifo_full", {31'b0, fifo_full}, {31'b0, occ == DEPTH});
            if (prev_stall) begin
                chk("hold_valid", {31'b0, bus.out_valid}, 32'd1);
                chk("hold_data", bus.out_data, prev_data);
                chk("hold_last", {31'b0, bus.out_last}, {31'b0, prev_last});
            end
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    tests_run++;
                    fails++;
                    $display("FAIL unexpected_word: got %h, expected no word", bus.out_data);
                end else begin
                    e = exp_q.pop_front();
                    chk("word_data", bus.out_data, e[31:0]);
                    chk("word_last", {31'b0, bus.out_last}, {31'b0, e[32]});
                end
                words_seen++;
            end
            prev_stall = bus.out_valid && !bus.out_ready;
            prev_data  = bus.out_data;
            prev_last  = bus.out_last;
        end else begin
            prev_stall = 1'b0;
        end
    end

    initial begin
        int base;
        int n;
        bit rdy_pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

        // Reset held with capture enabled: outputs stay cleared.
        bus.out_ready = 1'b1;
        trace_en = 1'b1;
        rand_inputs();
        repeat (4) begin
            cycle();
            chk("rst_valid", {31'b0, bus.out_valid}, 32'd0);
            chk("rst_last", {31'b0, bus.out_last}, 32'd0);
            chk("rst_data", bus.out_data, 32'd0);
            chk("rst_full", {31'b0, fifo_full}, 32'd0);
        end
        trace_en = 1'b0;
        rst_n = 1'b1;
        repeat (3) begin
            cycle();
            chk("idle_valid", {31'b0, bus.out_valid}, 32'd0);
        end

        // Single record with fixed expected words and latency.
        pc = 32'h0000_0010; instr = 32'h8C22_0004; wb = 32'd5; dest = 5'd3;
        reg_write = 1'b1; mem_write = 1'b0;
        trace_en = 1'b1;
        cycle();
        trace_en = 1'b0;
        chk("single_gap", {31'b0, bus.out_valid}, 32'd0);
        cycle();
        chk("single_w0", bus.out_data, 32'hA500_0083);
        chk("single_w0_last", {31'b0, bus.out_last}, 32'd0);
        cycle();
        chk("single_w1", bus.out_data, 32'h0000_0010);
        cycle();
        chk("single_w2", bus.out_data, 32'h8C22_0004);
        cycle();
        chk("single_w3", bus.out_data, 32'h0000_0005);
        chk("single_w3_last", {31'b0, bus.out_last}, 32'd1);
        cycle();
        chk("single_done", {31'b0, bus.out_valid}, 32'd0);
        drain();

        // Backpressure: ready toggles 1,0,0,1 while one frame drains.
        base = words_seen;
        trace_en = 1'b1;
        n = 0;
        bus.out_ready = rdy_pat[0];
        cycle();
        trace_en = 1'b0;
        while (words_seen < base + 4 && n < 60) begin
            n++;
            bus.out_ready = rdy_pat[n % 4];
            cycle();
        end
        bus.out_ready = 1'b1;
        repeat (4) cycle();
        chk("bp_handshakes", words_seen - base, 32'd4);

        // Overflow: one frame stalled in the serializer, then 10 captures into a DEPTH-4 FIFO.
        bus.out_ready = 1'b0;
        rand_inputs();
        trace_en = 1'b1;
        cycle();
        trace_en = 1'b0;
        cycle();
        for (int i = 0; i < 10; i++) begin
            rand_inputs();
            trace_en = 1'b1;
            cycle();
            if (i == 2) chk("ovf_not_full", {31'b0, fifo_full}, 32'd0);
            if (i == 3) chk("ovf_full", {31'b0, fifo_full}, 32'd1);
        end
        trace_en = 1'b0;
        bus.out_ready = 1'b1;
        n = 0;
        while (occ == DEPTH && n < 40) begin
            cycle();
            n++;
        end
        chk("ovf_space", {31'b0, fifo_full}, 32'd0);
        for (int i = 0; i < 2; i++) begin
            rand_inputs();
            trace_en = 1'b1;
            cycle();
        end
        drain();

        // Sequence wrap from a fresh reset: 300 captures, one every 4th cycle.
        do_reset();
        bus.out_ready = 1'b1;
        for (int i = 0; i < 300; i++) begin
            rand_inputs();
            trace_en = 1'b1;
            cycle();
            trace_en = 1'b0;
            repeat (3) cycle();
        end
        drain();

        // Random traffic.
        for (int i = 0; i < 500; i++) begin
            rand_inputs();
            trace_en = 1'($urandom_range(0, 1));
            bus.out_ready = $urandom_range(0, 9) < 7;
            cycle();
        end
        drain();

        // Reset asserted after W1 of a frame is accepted.
        base = words_seen;
        rand_inputs();
        trace_en = 1'b1;
        cycle();
        trace_en = 1'b0;
        n = 0;
        while (words_seen < base + 2 && n < 20) begin
            cycle();
            n++;
        end
        chk("midrst_reached_w1", {31'b0, words_seen >= base + 2}, 32'd1);
        #2;
        rst_n = 1'b0;
        model_clear();
        #1;
        chk("midrst_valid", {31'b0, bus.out_valid}, 32'd0);
        chk("midrst_data", bus.out_data, 32'd0);
        chk("midrst_last", {31'b0, bus.out_last}, 32'd0);
        @(negedge clk);
        cycle();
        rst_n = 1'b1;
        repeat (3) begin
            cycle();
            chk("midrst_no_resume", {31'b0, bus.out_valid}, 32'd0);
        end
        rand_inputs();
        trace_en = 1'b1;
        cycle();
        drain();

        chk("scoreboard_empty", exp_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule
